// File: rtl/keccak_pad_pkg.sv
// Shared constants and state type for the Keccak pad10*1 front end.
// Build option: define KECCAK_PAD_SHA3_EN to use the SHA-3 domain suffix 0x06 as the first pad byte.
package pkg_keccak;

  localparam int         RATE_WORDS = 16;
  localparam logic [3:0] LAST_LANE  = 4'(RATE_WORDS - 1);
  localparam logic [3:0] PRE_LAST   = 4'(RATE_WORDS - 2);

`ifdef KECCAK_PAD_SHA3_EN
  localparam logic [7:0] PAD_FIRST = 8'h06;
`else
  localparam logic [7:0] PAD_FIRST = 8'h01;
`endif

  localparam logic [7:0] PAD_LAST = 8'h80;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABSORB = 3'd1,
    PAD    = 3'd2,
    ZERO   = 3'd3,
    FINAL  = 3'd4,
    LAST   = 3'd5
  } pad_state_t;

  // Byte counts above a full lane are treated as a full lane.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] n);
    return (n > 4'd8) ? 4'd8 : n;
  endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// Combinational lane former: keeps bytes below n, inserts the first pad byte at n,
// and ORs the closing pad bit into byte 7 on the last lane of a block.
module keccak_pad_word
  import pkg_keccak::*;
(
  input  logic [63:0] msg,
  input  logic [3:0]  n,
  input  logic        last_lane,
  output logic [63:0] word
);

  always_comb begin
    word = 64'd0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < n) begin
        word[8*k +: 8] = msg[8*k +: 8];
      end else if (4'(k) == n) begin
        word[8*k +: 8] = PAD_FIRST;
      end else begin
        word[8*k +: 8] = 8'h00;
      end
    end
    word[63:56] = word[63:56] | ({8{last_lane}} & PAD_LAST);
  end

endmodule

// File: rtl/keccak_pad.sv
// pad10*1 stream padder for a 1024-bit-rate Keccak core (16 lanes of 64 bits).
// Build option: KECCAK_PAD_SHA3_EN selects the SHA-3 first pad byte (see pkg_keccak).
module keccak_pad
  import pkg_keccak::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [63:0] Msg_in,
  input  logic        Msg_valid,
  input  logic        Msg_last,
  input  logic [3:0]  Msg_bytes,
  output logic        Msg_ready,
  output logic        Start,
  output logic [63:0] Din,
  output logic        Din_valid,
  output logic        Last_block,
  input  logic        Buffer_full,
  input  logic        Ready
);

  pad_state_t  state;
  pad_state_t  next_state;
  logic [3:0]  cnt;
  logic [3:0]  msg_n;
  logic [63:0] word_msg;
  logic [3:0]  word_n;
  logic        word_last;
  logic [63:0] padded;

  assign msg_n = clamp_bytes(Msg_bytes);

  keccak_pad_word u_word (
    .msg       (word_msg),
    .n         (word_n),
    .last_lane (word_last),
    .word      (padded)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Lane counter advances on every accepted Din word and wraps at the block end.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= 4'd0;
    end else if (Start) begin
      cnt <= 4'd0;
    end else if (Din_valid) begin
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= cnt;
    end
  end

  always_comb begin
    next_state = state;
    Msg_ready  = 1'b0;
    Start      = 1'b0;
    Din        = 64'd0;
    Din_valid  = 1'b0;
    Last_block = 1'b0;
    word_msg   = 64'd0;
    word_n     = 4'd8;
    word_last  = 1'b0;

    case (state)
      IDLE: begin
        if (Msg_valid && Ready) begin
          Start      = 1'b1;
          next_state = ABSORB;
        end
      end
      ABSORB: begin
        Msg_ready = ~Buffer_full;
        Din_valid = Msg_valid & ~Buffer_full;
        word_msg  = Msg_in;
        if (Msg_last) begin
          word_n    = msg_n;
          word_last = (msg_n != 4'd8) && (cnt == LAST_LANE);
        end
        Din = padded;
        if (Din_valid && Msg_last) begin
          if (msg_n == 4'd8) begin
            next_state = PAD;
          end else if (cnt == LAST_LANE) begin
            next_state = LAST;
          end else begin
            next_state = ZERO;
          end
        end
      end
      PAD: begin
        Din_valid = ~Buffer_full;
        word_n    = 4'd0;
        word_last = (cnt == LAST_LANE);
        Din       = padded;
        if (Din_valid) begin
          next_state = (cnt == LAST_LANE) ? LAST : ZERO;
        end
      end
      ZERO: begin
        // Pad landed on lane 14: lane 15 still needs the closing bit, nothing to zero-fill.
        if (cnt == LAST_LANE) begin
          next_state = FINAL;
        end else begin
          Din_valid = ~Buffer_full;
          if (Din_valid && (cnt == PRE_LAST)) begin
            next_state = FINAL;
          end
        end
      end
      FINAL: begin
        Din_valid = ~Buffer_full;
        word_last = 1'b1;
        word_n    = 4'd8;
        Din       = padded;
        if (Din_valid) begin
          next_state = LAST;
        end
      end
      LAST: begin
        if (Ready && !Buffer_full) begin
          Last_block = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    if (Reset) begin
      next_state = IDLE;
      Msg_ready  = 1'b0;
      Start      = 1'b0;
      Din        = 64'd0;
      Din_valid  = 1'b0;
      Last_block = 1'b0;
    end
  end

endmodule

// File: doc/keccak_pad.md
KECCAK_PAD -- requirements
Module: keccak_pad

Interface
REQ-001 Clock  in  1  rising-edge clock; sole clock domain.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 Msg_in  in  64  message word; byte k = bits [8k+7:8k].
REQ-004 Msg_valid  in  1  Msg_in holds a valid word.
REQ-005 Msg_last  in  1  qualifies the final message word.
REQ-006 Msg_bytes  in  4  valid bytes in the final word, 0..8; ignored unless Msg_last.
REQ-007 Msg_ready  out  1  word accepted when Msg_valid & Msg_ready.
REQ-008 Start  out  1  one-cycle pulse that clears the core state.
REQ-009 Din  out  64  padded word to the core.
REQ-010 Din_valid  out  1  Din presented; never high while Buffer_full.
REQ-011 Last_block  out  1  one-cycle end-of-message pulse to the core.
REQ-012 Buffer_full  in  1  core input buffer holds a full block.
REQ-013 Ready  in  1  core permutation idle.

Function
REQ-014 The block SHALL implement pad10*1 for rate 1024 bits (RATE_WORDS=16 lanes of 64 bits).
REQ-015 States SHALL be IDLE, ABSORB, PAD, ZERO, FINAL, LAST.
REQ-016 IDLE: when Msg_valid & Ready, the block SHALL pulse Start for one cycle, then enter ABSORB; no word is consumed in that cycle.
REQ-017 ABSORB: Msg_ready = ~Buffer_full; Din_valid = Msg_valid & ~Buffer_full.
REQ-018 For a non-last word, Din SHALL equal Msg_in unmodified.
REQ-019 A word counter (0..15, wrapping to 0) SHALL increment on every Din transfer (Din_valid & ~Buffer_full).
REQ-020 For a last word with n = Msg_bytes < 8: bytes >= n SHALL be zeroed; byte n = PAD_FIRST (0x01); if the counter is 15, byte 7 is additionally ORed with 0x80; next state is ZERO, or LAST if the counter is 15.
REQ-021 For a last word with n = 8: Din = Msg_in; next state is PAD.
REQ-022 PAD: the block SHALL emit the word 0x...01 (byte 0 = PAD_FIRST), ORed with byte 7 = 0x80 if the counter is 15; next state is ZERO or LAST accordingly.
REQ-023 ZERO: the block SHALL emit all-zero words until the counter is 14, then enter FINAL.
REQ-024 FINAL: the block SHALL emit a word with byte 7 = 0x80, all other bytes zero; next state is LAST.
REQ-025 LAST: when Ready & ~Buffer_full, the block SHALL pulse Last_block for one cycle with Din_valid=0, then return to IDLE.
REQ-026 In PAD/ZERO/FINAL, Msg_ready SHALL be 0 and Din_valid SHALL be ~Buffer_full.
REQ-027 An empty message (Msg_last, Msg_bytes=0 on the first word) SHALL yield word 0 = 0x01, words 1..14 = 0, word 15 = 0x8000000000000000.
REQ-028 Msg_bytes > 8 SHALL be treated as 8.

Reset
REQ-029 On Reset: state = IDLE, counter = 0, Start = 0, Din_valid = 0, Last_block = 0, Msg_ready = 0, Din = 0.
REQ-030 Reset asserted mid-message SHALL abandon the message; any partial core block is cleared by the next Start pulse.

Configuration
REQ-031 With KECCAK_PAD_SHA3_EN defined, PAD_FIRST SHALL be 0x06 (SHA-3 domain suffix); without it, PAD_FIRST SHALL be 0x01 (original Keccak). In either case the final 0x80 bit is unchanged.

Structure
REQ-032 pkg_keccak SHALL hold RATE_WORDS, PAD_FIRST, PAD_LAST (0x80) and the state enum typedef.
REQ-033 A combinational sub-module, keccak_pad_word, SHALL produce the byte mask and pad insertion from (Msg_in, n, last-lane flag).

Verification
REQ-034 Empty message -> Start pulse, 16 words {0x01, 14x0, 0x8000000000000000}, then a Last_block pulse.
REQ-035 3-byte message 0xCCBBAA (Msg_bytes=3) -> word 0 = 0x0000000001CCBBAA, words 1..14 = 0, word 15 = 0x8000000000000000.
REQ-036 16 full words -> second block {0x01, 14x0, 0x80<<56}; Last_block asserted only after Ready.
REQ-037 15 full words plus a last word with Msg_bytes=7 -> word 15 = 0x81 in byte 7 plus the 7 data bytes; single block; LAST entered.
REQ-038 Buffer_full held high for 24 cycles mid-block -> Msg_ready=0 and Din_valid=0 throughout; no word lost or duplicated.
REQ-039 Reset asserted during ZERO -> all outputs 0 next cycle; the following message is padded correctly from counter 0.
